// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for a 32-point radix-2 MDC FFT pipeline.
// A frame is 16 cycles of paired samples. A global cycle counter drives
// the stage commutators and the twiddle ROM indices. The controller
// zero-fills gaps inside a frame and flushes the pipeline after the last
// frame. It also produces output valid and frame-start flags that are
// delayed by the datapath latency.
module fft_ctrl #(
  parameter int PIPE_LAT = 24,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_err,
  output logic [CNT_W-1:0] state_code,
  output logic [3:0]       rom_16_counter,
  output logic [2:0]       rom_8_counter,
  output logic [1:0]       rom_4_counter,
  output logic             zero_fill,
  output logic             out_valid,
  output logic             out_first,
  output logic             busy,
  output logic             err_gap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Flush counter is one bit wider than needed for PIPE_LAT = 127, so it cannot wrap.
  localparam int               FC_W      = 8;
  localparam logic [FC_W-1:0]  FLUSH_END = FC_W'(PIPE_LAT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  g, g_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_nxt;
  logic              err_nxt;
  logic              slot0;
  logic              accept;
  logic              vld_p0;
  logic              first_p0;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] first_sr;

  // Handshake, gap detection and per-cycle datapath qualifiers.
  always_comb begin
    slot0     = (g[3:0] == 4'd0);
    // During a flush, a new frame may only start at a frame boundary.
    in_ready  = (state == FLUSH) ? slot0 : 1'b1;
    accept    = in_valid & in_ready;
    zero_fill = (state == RUN) & ~slot0 & ~in_valid;
    vld_p0    = accept | zero_fill;
    first_p0  = vld_p0 & slot0;
  end

  // Next-state, counter and sticky-error logic.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    flush_nxt = flush_cnt;
    case (state)
      IDLE: begin
        g_nxt     = '0;
        flush_nxt = '0;
        if (accept) begin
          state_nxt = RUN;
          g_nxt     = CNT_W'(1);
        end
      end
      RUN: begin
        g_nxt     = g + 1'b1;
        flush_nxt = '0;
        if (slot0 && !in_valid) begin
          state_nxt = FLUSH;
          flush_nxt = FC_W'(1);
        end
      end
      FLUSH: begin
        g_nxt     = g + 1'b1;
        flush_nxt = flush_cnt + 1'b1;
        // An accept on the last flush cycle takes priority over returning to idle.
        if (accept) begin
          state_nxt = RUN;
          flush_nxt = '0;
        end else if (flush_cnt == FLUSH_END) begin
          state_nxt = IDLE;
          g_nxt     = '0;
          flush_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        g_nxt     = '0;
        flush_nxt = '0;
      end
    endcase

    // Setting the error takes priority over a clear in the same cycle.
    err_nxt = err_gap;
    if (zero_fill)
      err_nxt = 1'b1;
    else if (clr_err || (state == IDLE && accept))
      err_nxt = 1'b0;
  end

  // State, global cycle counter, flush counter and error flag registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      g         <= '0;
      flush_cnt <= '0;
      err_gap   <= 1'b0;
    end else begin
      state     <= state_nxt;
      g         <= g_nxt;
      flush_cnt <= flush_nxt;
      err_gap   <= err_nxt;
    end
  end

  // Delay lines that align the valid and first flags with the datapath latency.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_sr   <= '0;
      first_sr <= '0;
    end else begin
      vld_sr[0]   <= vld_p0;
      first_sr[0] <= first_p0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_sr[i]   <= vld_sr[i-1];
        first_sr[i] <= first_sr[i-1];
      end
    end
  end

  // Registered state drives the outputs; the ROM indices are slices of the counter.
  always_comb begin
    state_code     = g;
    rom_16_counter = g[3:0];
    rom_8_counter  = g[2:0];
    rom_4_counter  = g[1:0];
    busy           = (state != IDLE);
    out_valid      = vld_sr[PIPE_LAT-1];
    out_first      = first_sr[PIPE_LAT-1];
  end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
Sequencer for the 32-point radix-2 MDC FFT pipeline. Each frame is 16 cycles of paired samples, upper and lower.
- Accepts input frames through a valid/ready handshake.
- Runs a global cycle counter. The counter drives the stage commutators through state_code and the twiddle ROM address counters, such as rom_4_counter.
- Zero-fills gaps inside a frame and flushes the pipeline after the last frame.
- Generates output valid and frame-start flags, aligned to the datapath latency.

Parameters:
PIPE_LAT, 24, cycles from a frame's first accepted pair to its first output pair (range 1..127).
CNT_W, 7, width of the global cycle counter and state_code.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-high reset (1 = reset)
in_valid  in  1  upstream has a sample pair this cycle
in_ready  out  1  controller accepts a pair this cycle
clr_err  in  1  synchronous clear of err_gap
state_code  out  7  global cycle counter g, feeds the stage commutators
rom_16_counter  out  4  stage-1 twiddle index = g[3:0]
rom_8_counter  out  3  stage-2 twiddle index = g[2:0]
rom_4_counter  out  2  stage-3 twiddle index = g[1:0]
zero_fill  out  1  datapath must substitute 0 for the input pair this cycle
out_valid  out  1  datapath output pair is valid
out_first  out  1  output pair is slot 0 of a frame
busy  out  1  state != IDLE
err_gap  out  1  sticky: an in-frame input gap occurred

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; g = 0; flush_cnt = 0; err_gap = 0.
  - Both PIPE_LAT-deep delay lines are cleared.
  - Output values: state_code = 0, all ROM counters = 0, zero_fill = 0, out_valid = 0, out_first = 0, busy = 0, in_ready = 1.
  - Reset mid-frame abandons the frame; out_valid drops in the same cycle.
- Definitions:
  - slot = g[3:0].
  - accept = in_valid & in_ready.
  - ROM counters are combinational slices of g. state_code = g.
- IDLE:
  - g is held at 0; in_ready = 1.
  - On accept, that cycle is slot 0 of a new frame; err_gap clears; next state is RUN with g = 1.
- RUN:
  - g increments every cycle, wrapping 127 -> 0; in_ready = 1.
  - At slot != 0 with in_valid = 0: zero_fill = 1 for that cycle, err_gap sets, and the slot still counts.
  - At slot 0 with in_valid = 1: back-to-back frame, stay in RUN.
  - At slot 0 with in_valid = 0: enter FLUSH with flush_cnt = 1; g keeps counting.
- FLUSH:
  - g keeps counting.
  - in_ready = 1 only when slot == 0. An accept at slot 0 starts a new frame and returns to RUN; flush_cnt clears.
  - in_valid at slot != 0 is ignored: no accept, no error.
  - flush_cnt increments each cycle. When flush_cnt == PIPE_LAT and no accept occurs, go to IDLE with g = 0.
  - If flush_cnt == PIPE_LAT and slot == 0 with accept in the same cycle, the accept wins and the state goes to RUN.
- Delay lines:
  - act = accept | zero_fill; first = act & (slot == 0).
  - Two PIPE_LAT-deep 1-bit shift registers run every cycle, including in IDLE.
  - out_valid = act delayed by PIPE_LAT; out_first = first delayed by PIPE_LAT.
  - Every frame therefore produces exactly 16 consecutive out_valid cycles.
- err_gap:
  - Set by zero_fill.
  - Cleared by clr_err or by a new frame start from IDLE; set wins over a simultaneous clr_err.
- Outputs are combinational from registered state; no combinational path from in_valid to in_ready.

Test Plan:
1. Reset, then in_valid = 1 for 16 cycles from t0:
   - state_code steps 0..15 and rom_4_counter 0,1,2,3 repeating.
   - out_valid is high t0+24..t0+39; out_first is high at t0+24 only.
   - FLUSH runs 24 cycles, then IDLE, busy = 0, state_code = 0.
2. Two back-to-back frames (32 cycles of in_valid): state stays RUN throughout; out_valid is high for 32 contiguous cycles; out_first pulses at t0+24 and t0+40.
3. Frame with in_valid = 0 at slots 5 and 6:
   - zero_fill is high in exactly those two cycles and err_gap stays 1 afterwards.
   - out_valid is still 16 contiguous cycles.
   - clr_err = 1 returns err_gap to 0.
4. in_valid held high during FLUSH:
   - in_ready = 0 and no accept at slots 1..15.
   - Accept occurs at the next slot 0 and the state returns to RUN.
   - out_first appears 24 cycles after that slot.
5. rst_n asserted at slot 9 of a frame: all outputs reach their reset values immediately; the pending out_valid pulses never appear; a new frame after release restarts at state_code = 0.
6. Continuous input for 130 cycles: state_code wraps 127 -> 0 without glitching zero_fill, in_ready or the out_first pattern, which pulses every 16 cycles.
